// File: rtl/cam_pkg.sv
// Shared camera-path definitions: capture FSM encoding and default frame geometry.
package cam_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_SYNC    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } cap_state_e;

   localparam int IMG_W_DEF = 160;
   localparam int IMG_H_DEF = 120;

endpackage

// File: rtl/sync_edge_det.sv
// One-stage edge detector: registers the input and flags rise/fall against the registered copy.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) din_q <= 1'b0;
      else      din_q <= din;
   end

   assign rise = din & ~din_q;
   assign fall = ~din & din_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer gating cam_read writes into the frame buffer, with geometry checks.
// Optional watchdog enabled by defining CAPTURE_TIMEOUT_EN.
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int CNT_W = 15
`ifdef CAPTURE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 2000000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_single,
   input  logic       CAM_vsync,
   input  logic       CAM_href,
   input  logic       cam_regW,
   output logic       DP_RAM_regW,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic       err_geom,
   output logic       err_timeout
);

   localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);
   localparam logic [CNT_W-1:0] LINE_PIX  = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] NUM_LINES = CNT_W'(IMG_H);

   cap_state_e       state_q, state_d;
   logic             single_q, single_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic             err_geom_q, err_geom_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] pix_now;
   logic             dp_we;
   logic             done_pulse;
   logic             timeout;
   logic             vs_rise, vs_fall, hr_fall, hr_rise_unused;

   sync_edge_det u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (CAM_vsync),
      .rise (vs_rise),
      .fall (vs_fall)
   );

   sync_edge_det u_hr_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (CAM_href),
      .rise (hr_rise_unused),
      .fall (hr_fall)
   );

   always_comb begin
      state_d     = state_q;
      single_d    = single_q;
      frame_cnt_d = frame_cnt_q;
      err_geom_d  = err_geom_q;
      wr_cnt_d    = wr_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      line_cnt_d  = line_cnt_q;
      dp_we       = 1'b0;
      done_pulse  = 1'b0;
      pix_now     = pix_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_start) begin
               state_d     = ST_ARM;
               single_d    = cmd_single;
               frame_cnt_d = 8'd0;
               err_geom_d  = 1'b0;
            end
         end
         ST_ARM: begin
            if (CAM_vsync) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            wr_cnt_d   = '0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            if (vs_fall) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            dp_we = cam_regW && (wr_cnt_q < FRAME_PIX);
            if (cam_regW && !dp_we) err_geom_d = 1'b0 | 1'b1;
            // A write landing on the href-fall cycle still belongs to the ending line.
            pix_now   = pix_cnt_q + CNT_W'(dp_we);
            wr_cnt_d  = wr_cnt_q + CNT_W'(dp_we);
            pix_cnt_d = pix_now;
            if (hr_fall) begin
               if (pix_now != LINE_PIX) err_geom_d = 1'b1;
               pix_cnt_d  = '0;
               line_cnt_d = line_cnt_q + CNT_W'(1);
            end
            if (vs_rise) begin
               state_d = ST_DONE;
               if ((line_cnt_d != NUM_LINES) || (wr_cnt_d != FRAME_PIX)) err_geom_d = 1'b1;
            end
         end
         ST_DONE: begin
            done_pulse  = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = single_q ? ST_IDLE : ST_SYNC;
         end
         default: state_d = ST_IDLE;
      endcase

      if (cmd_stop) begin
         state_d     = ST_IDLE;
         single_d    = single_q;
         frame_cnt_d = frame_cnt_q;
         err_geom_d  = err_geom_q;
         dp_we       = 1'b0;
         done_pulse  = 1'b0;
      end else if (timeout) begin
         state_d = ST_IDLE;
      end
   end

`ifdef CAPTURE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_timeout_q, err_timeout_d;

   always_comb begin
      timeout = ((state_q == ST_ARM) || (state_q == ST_SYNC) || (state_q == ST_CAPTURE))
                && (wd_q == WD_W'(TIMEOUT_CYC - 1));
      wd_d = ((state_d != state_q) || vs_rise || vs_fall) ? '0 : wd_q + WD_W'(1);
      err_timeout_d = err_timeout_q;
      if ((state_q == ST_IDLE) && cmd_start && !cmd_stop) err_timeout_d = 1'b0;
      if (timeout && !cmd_stop) err_timeout_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q          <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         wd_q          <= wd_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         single_q    <= 1'b0;
         frame_cnt_q <= 8'd0;
         err_geom_q  <= 1'b0;
         wr_cnt_q    <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         single_q    <= single_d;
         frame_cnt_q <= frame_cnt_d;
         err_geom_q  <= err_geom_d;
         wr_cnt_q    <= wr_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         line_cnt_q  <= line_cnt_d;
      end
   end

   assign DP_RAM_regW = dp_we;
   assign busy        = (state_q != ST_IDLE);
   assign frame_done  = done_pulse;
   assign frame_cnt   = frame_cnt_q;
   assign err_geom    = err_geom_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl on a reduced 16x12 geometry; covers the watchdog when
// CAPTURE_TIMEOUT_EN is defined.
module tb_cam_capture_ctrl;

   localparam int TW = 16;
   localparam int TH = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_start = 1'b0, cmd_stop = 1'b0, cmd_single = 1'b0;
   logic       CAM_vsync = 1'b0, CAM_href = 1'b0, cam_regW = 1'b0;
   logic       DP_RAM_regW, busy, frame_done, err_geom, err_timeout;
   logic [7:0] frame_cnt;

   typedef struct {
      int   wr;
      logic err;
      int   fcnt;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   tot_wr = 0;
   int   frame_wr = 0;
   int   base;

   always #5 clk = ~clk;

   cam_capture_ctrl #(
      .IMG_W(TW), .IMG_H(TH), .CNT_W(8)
`ifdef CAPTURE_TIMEOUT_EN
      , .TIMEOUT_CYC(1000)
`endif
   ) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_single(cmd_single),
      .CAM_vsync(CAM_vsync), .CAM_href(CAM_href), .cam_regW(cam_regW),
      .DP_RAM_regW(DP_RAM_regW), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .err_geom(err_geom), .err_timeout(err_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: counts gated writes and checks each frame_done against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (DP_RAM_regW) begin
            tot_wr++;
            frame_wr++;
         end
         if (frame_done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame_done", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               $display("frame_done: writes=%0d err_geom=%0d frame_cnt=%0d", frame_wr, err_geom, frame_cnt);
               check("frame_writes", frame_wr, e.wr);
               check("frame_err_geom", {31'd0, err_geom}, {31'd0, e.err});
               check("frame_cnt_at_done", {24'd0, frame_cnt}, e.fcnt);
            end
            frame_wr = 0;
         end
         if (!busy) frame_wr = 0;
      end
   end

   task automatic drive(input logic vs, input logic hr, input logic we);
      CAM_vsync = vs;
      CAM_href  = hr;
      cam_regW  = we;
      @(posedge clk);
      #1;
   endtask

   task automatic blank();
      repeat (3) drive(1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_line(input int n, input logic poke);
      repeat (n) drive(1'b0, 1'b1, 1'b1);
      if (poke) begin
         cmd_start  = 1'b1;
         cmd_single = 1'b1;
      end
      drive(1'b0, 1'b0, 1'b0);
      cmd_start  = 1'b0;
      cmd_single = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame(input int nlines, input int poke_line);
      blank();
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      for (int l = 0; l < nlines; l++) run_line(TW, l == poke_line);
   endtask

   task automatic start(input logic single);
      cmd_start  = 1'b1;
      cmd_single = single;
      drive(1'b0, 1'b0, 1'b0);
      cmd_start  = 1'b0;
      cmd_single = 1'b0;
   endtask

   task automatic stop();
      cmd_stop = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      cmd_stop = 1'b0;
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_regw", {31'd0, DP_RAM_regW}, 0);
      check("rst_frame_cnt", {24'd0, frame_cnt}, 0);
      check("rst_err", {30'd0, err_geom, err_timeout}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      // 1: single shot, started mid-frame
      blank();
      run_line(TW, 1'b0);
      run_line(TW, 1'b0);
      start(1'b1);
      check("t1_busy_after_start", {31'd0, busy}, 1);
      base = tot_wr;
      repeat (3) run_line(TW, 1'b0);
      check("t1_no_write_midframe", tot_wr - base, 0);
      sb_q.push_back('{TW * TH, 1'b0, 0});
      base = tot_wr;
      frame(TH, -1);
      blank();
      check("t1_writes", tot_wr - base, TW * TH);
      check("t1_idle", {31'd0, busy}, 0);
      check("t1_frame_cnt", {24'd0, frame_cnt}, 1);

      // 2: continuous, three frames
      start(1'b0);
      base = tot_wr;
      for (int f = 0; f < 3; f++) begin
         sb_q.push_back('{TW * TH, 1'b0, f});
         frame(TH, -1);
      end
      blank();
      check("t2_busy", {31'd0, busy}, 1);
      check("t2_frame_cnt", {24'd0, frame_cnt}, 3);
      check("t2_err_geom", {31'd0, err_geom}, 0);
      check("t2_writes", tot_wr - base, 3 * TW * TH);
      stop();
      check("t2_stopped", {31'd0, busy}, 0);

      // 3: stop in the middle of line 6
      start(1'b1);
      blank();
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      repeat (5) run_line(TW, 1'b0);
      repeat (5) drive(1'b0, 1'b1, 1'b1);
      cmd_stop  = 1'b1;
      CAM_href  = 1'b1;
      cam_regW  = 1'b1;
      @(negedge clk);
      check("t3_regw_drop", {31'd0, DP_RAM_regW}, 0);
      @(posedge clk);
      #1;
      cmd_stop = 1'b0;
      check("t3_idle", {31'd0, busy}, 0);
      base = tot_wr;
      repeat (TW - 6) drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      repeat (5) run_line(TW, 1'b0);
      blank();
      check("t3_no_write_after_stop", tot_wr - base, 0);
      check("t3_frame_cnt", {24'd0, frame_cnt}, 0);

      // 4a: short line 3 (14 writes)
      start(1'b1);
      sb_q.push_back('{TW * TH - 2, 1'b1, 0});
      blank();
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      for (int l = 0; l < TH; l++) begin
         run_line((l == 3) ? TW - 2 : TW, 1'b0);
         if (l == 2) check("t4_err_before_short", {31'd0, err_geom}, 0);
         if (l == 3) check("t4_err_at_short", {31'd0, err_geom}, 1);
      end
      blank();

      // 4b: long frame, 13 lines
      start(1'b1);
      check("t4_err_cleared", {31'd0, err_geom}, 0);
      sb_q.push_back('{TW * TH, 1'b1, 0});
      base = tot_wr;
      blank();
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      for (int l = 0; l < TH + 1; l++) begin
         run_line(TW, 1'b0);
         if (l == TH - 1) check("t4_err_full_frame", {31'd0, err_geom}, 0);
         if (l == TH) check("t4_err_long", {31'd0, err_geom}, 1);
      end
      blank();
      check("t4_long_writes", tot_wr - base, TW * TH);
      check("t4_long_idle", {31'd0, busy}, 0);

      // 5: start+stop together; start while busy
      cmd_start = 1'b1;
      cmd_stop  = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
      check("t5_start_stop", {31'd0, busy}, 0);
      check("t5_cnt_kept", {24'd0, frame_cnt}, 1);
      start(1'b0);
      sb_q.push_back('{TW * TH, 1'b0, 0});
      frame(TH, 4);
      sb_q.push_back('{TW * TH, 1'b0, 1});
      frame(TH, -1);
      blank();
      check("t5_still_continuous", {31'd0, busy}, 1);
      check("t5_frame_cnt", {24'd0, frame_cnt}, 2);
      stop();

      // Reset asserted mid-capture
      start(1'b1);
      blank();
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      run_line(TW, 1'b0);
      repeat (3) drive(1'b0, 1'b1, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_regw", {31'd0, DP_RAM_regW}, 0);
      check("rst_mid_busy", {31'd0, busy}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      check("rst_mid_frame_cnt", {24'd0, frame_cnt}, 0);

      // 6: vsync held low while armed
      start(1'b1);
`ifdef CAPTURE_TIMEOUT_EN
      repeat (999) drive(1'b0, 1'b0, 1'b0);
      check("t6_before_timeout", {31'd0, busy}, 1);
      check("t6_no_err_yet", {31'd0, err_timeout}, 0);
      drive(1'b0, 1'b0, 1'b0);
      check("t6_timeout_idle", {31'd0, busy}, 0);
      check("t6_err_timeout", {31'd0, err_timeout}, 1);
`else
      repeat (1100) drive(1'b0, 1'b0, 1'b0);
      check("t6_still_armed", {31'd0, busy}, 1);
      check("t6_err_timeout", {31'd0, err_timeout}, 0);
      stop();
`endif

      check("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
